// File: rtl/pc_fetch_ctrl_pkg.sv
// ============================================================================
// pc_fetch_ctrl_pkg : shared types and constants for the IF-stage PC controller
// Rev 1.0
// ============================================================================
`default_nettype none

package pc_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } pc_state_t;

    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/pc_fetch_ctrl_if.sv
// ============================================================================
// pc_fetch_ctrl_if : redirect inputs and fetch outputs of the PC controller
// Rev 1.0  (counter signals present only when PC_PERF_CNT_EN is defined)
// ============================================================================
`default_nettype none

interface pc_fetch_ctrl_if #(
    parameter int CNT_W = 32
);
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_base_pc;
    logic [31:0] branch_offset_sh;
    logic        jump;
    logic [31:0] jump_base_pc;
    logic [27:0] jump_target_sh;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        if_valid;
    logic        flush_ifid;
`ifdef PC_PERF_CNT_EN
    logic [CNT_W-1:0] redirect_cnt;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output stall, branch_taken, branch_base_pc, branch_offset_sh,
               jump, jump_base_pc, jump_target_sh,
        input  pc, pc_plus4, if_valid, flush_ifid, redirect_cnt, stall_cnt
    );
    modport slave (
        input  stall, branch_taken, branch_base_pc, branch_offset_sh,
               jump, jump_base_pc, jump_target_sh,
        output pc, pc_plus4, if_valid, flush_ifid, redirect_cnt, stall_cnt
    );
`else
    modport master (
        output stall, branch_taken, branch_base_pc, branch_offset_sh,
               jump, jump_base_pc, jump_target_sh,
        input  pc, pc_plus4, if_valid, flush_ifid
    );
    modport slave (
        input  stall, branch_taken, branch_base_pc, branch_offset_sh,
               jump, jump_base_pc, jump_target_sh,
        output pc, pc_plus4, if_valid, flush_ifid
    );
`endif

endinterface

`default_nettype wire

// File: rtl/pc_fetch_ctrl_target_calc.sv
// ============================================================================
// pc_target_calc : combinational branch/jump target formation and selection
// Rev 1.0
// ============================================================================
`default_nettype none

module pc_target_calc (
    input  wire logic        branch_taken_i,
    input  wire logic [31:0] branch_base_pc_i,
    input  wire logic [31:0] branch_offset_sh_i,
    input  wire logic        jump_i,
    input  wire logic [31:0] jump_base_pc_i,
    input  wire logic [27:0] jump_target_sh_i,
    output logic      [31:0] target_o,
    output logic             redirect_o
);

    logic [31:0] w_br_tgt;
    logic [31:0] w_j_tgt;

    assign w_br_tgt = branch_base_pc_i + branch_offset_sh_i;
    assign w_j_tgt  = {jump_base_pc_i[31:28], jump_target_sh_i};

    // The branch is the older instruction in the pipe, so it wins over a jump.
    assign target_o   = branch_taken_i ? w_br_tgt : w_j_tgt;
    assign redirect_o = branch_taken_i | jump_i;

endmodule

`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
// ============================================================================
// pc_fetch_ctrl : IF-stage program counter, next-PC sequencing and IF/ID flush
// Rev 1.0  (optional performance counters: define PC_PERF_CNT_EN)
// ============================================================================
`default_nettype none

module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          CNT_W    = 32
) (
    input  wire logic        clk,
    input  wire logic        rst,
    pc_fetch_ctrl_if.slave   bus
);

    pc_state_t   state_q;
    logic [31:0] pc_q;
    logic [31:0] pend_pc_q;
    logic        if_valid_q;

    logic [31:0] w_target;
    logic        w_redirect;
    logic        w_flush;

    pc_target_calc u_target_calc (
        .branch_taken_i     (bus.branch_taken),
        .branch_base_pc_i   (bus.branch_base_pc),
        .branch_offset_sh_i (bus.branch_offset_sh),
        .jump_i             (bus.jump),
        .jump_base_pc_i     (bus.jump_base_pc),
        .jump_target_sh_i   (bus.jump_target_sh),
        .target_o           (w_target),
        .redirect_o         (w_redirect)
    );

    always_comb begin
        w_flush = 1'b0;
        case (state_q)
            RUN:     w_flush = w_redirect & ~bus.stall;
            HOLD:    w_flush = ~bus.stall;
            default: w_flush = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            pend_pc_q  <= 32'd0;
            if_valid_q <= 1'b0;
        end else begin
            case (state_q)
                BOOT: begin
                    state_q    <= RUN;
                    if_valid_q <= 1'b1;
                end
                RUN: begin
                    if (w_redirect) begin
                        if (bus.stall) begin
                            pend_pc_q <= w_target;
                            state_q   <= HOLD;
                        end else begin
                            pc_q <= w_target;
                        end
                    end else if (!bus.stall) begin
                        pc_q <= pc_q + PC_INC;
                    end
                end
                HOLD: begin
                    // Redirects arriving while a deferred one waits are wrong-path.
                    if (!bus.stall) begin
                        pc_q    <= pend_pc_q;
                        state_q <= RUN;
                    end
                end
                default: begin
                    state_q    <= BOOT;
                    if_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc         = pc_q;
    assign bus.pc_plus4   = pc_q + PC_INC;
    assign bus.if_valid   = if_valid_q;
    assign bus.flush_ifid = w_flush;

`ifdef PC_PERF_CNT_EN
    logic [CNT_W-1:0] redirect_cnt_q;
    logic [CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_cnt_q <= '0;
            stall_cnt_q    <= '0;
        end else begin
            if (w_flush && (redirect_cnt_q != '1)) begin
                redirect_cnt_q <= redirect_cnt_q + 1'b1;
            end
            if (bus.stall && (state_q != BOOT) && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign bus.redirect_cnt = redirect_cnt_q;
    assign bus.stall_cnt    = stall_cnt_q;
`endif

endmodule

`default_nettype wire
